// File: rtl/tow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tow_pkg
// Description : Shared types and constants for the Tug-of-War round sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package tow_pkg;

  typedef enum logic [2:0] {
    S_CLEAR    = 3'd0,
    S_WAIT     = 3'd1,
    S_LIGHT    = 3'd2,
    S_REPORT   = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Width of one shared counter that must hold the longest delay, HOLD and TIMEOUT
  function automatic int cnt_width(input int dmin, input int rbits, input int step,
                                   input int hold, input int tmo);
    int m;
    m = dmin + (((1 << rbits) - 1) << step);
    if (hold > m) m = hold;
    if (tmo > m) m = tmo;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tow_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : tow_lfsr
// Description : 16-bit Fibonacci LFSR, steps every cycle, never reaches zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tow_lfsr
  import tow_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule
`default_nettype wire

// File: rtl/tow_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tow_round_ctrl
// Description : Tug-of-War round sequencer: hold-off, random delay, cue, arbitration.
//               Optional fake-cue rounds when TOW_FAKE_ROUND_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tow_round_ctrl
  import tow_pkg::*;
#(
  parameter int DELAY_MIN = 32,
  parameter int RAND_BITS = 4,
  parameter int STEP_LOG2 = 3,
  parameter int HOLD      = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_l,
  input  logic pb_r,
  input  logic wingame,
  output logic winrnd,
  output logic right,
  output logic tie,
  output logic leds_on,
  output logic fake,
  output logic busy
);

  localparam int            CW        = cnt_width(DELAY_MIN, RAND_BITS, STEP_LOG2, HOLD, TIMEOUT);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic [15:0]   lfsr;
  logic          pb_l_q;
  logic          pb_r_q;
  logic          press_l;
  logic          press_r;
  logic [CW-1:0] cnt;
  logic [CW-1:0] delay_load;
  logic          fake_pick;
  logic          unused_lfsr;
  state_t        state;

  tow_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign delay_load  = CW'(DELAY_MIN) + (CW'(lfsr[RAND_BITS-1:0]) << STEP_LOG2);
  assign unused_lfsr = ^lfsr;

`ifdef TOW_FAKE_ROUND_EN
  assign fake_pick = (lfsr[15:14] == 2'b11);
`else
  assign fake_pick = 1'b0;
`endif

  // Previous levels reset high so a button held through reset is not a press
  always_ff @(posedge clk) begin
    if (rst) begin
      pb_l_q  <= 1'b1;
      pb_r_q  <= 1'b1;
      press_l <= 1'b0;
      press_r <= 1'b0;
    end else begin
      pb_l_q  <= pb_l;
      pb_r_q  <= pb_r;
      press_l <= pb_l & ~pb_l_q;
      press_r <= pb_r & ~pb_r_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      cnt     <= '0;
      winrnd  <= 1'b0;
      right   <= 1'b0;
      tie     <= 1'b0;
      leds_on <= 1'b0;
      fake    <= 1'b0;
      busy    <= 1'b1;
    end else begin
      winrnd <= 1'b0;
      if (wingame && (state != S_GAMEOVER)) begin
        state   <= S_GAMEOVER;
        leds_on <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_CLEAR: begin
            leds_on <= 1'b0;
            tie     <= 1'b0;
            if (pb_l || pb_r) begin
              cnt <= '0;
            end else if (cnt == HOLD_LAST) begin
              cnt   <= delay_load;
              right <= 1'b0;
              fake  <= 1'b0;
              state <= S_WAIT;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          S_WAIT: begin
            if (press_l || press_r) begin
              right  <= press_r;
              tie    <= press_l & press_r;
              winrnd <= 1'b1;
              state  <= S_REPORT;
            end else if (cnt == '0) begin
              leds_on <= 1'b1;
              fake    <= fake_pick;
              state   <= S_LIGHT;
            end else begin
              cnt <= cnt - ONE;
            end
          end
          S_LIGHT: begin
            if (press_l || press_r) begin
              right  <= press_r & ~press_l;
              tie    <= press_l & press_r;
              winrnd <= 1'b1;
              state  <= S_REPORT;
            end else if (cnt == TMO_LAST) begin
              leds_on <= 1'b0;
              cnt     <= '0;
              state   <= S_CLEAR;
            end else begin
              cnt <= cnt + ONE;
            end
          end
          // Qualifiers were stable during the winrnd cycle; now leave for CLEAR
          S_REPORT: begin
            leds_on <= 1'b0;
            tie     <= 1'b0;
            cnt     <= '0;
            state   <= S_CLEAR;
          end
          S_GAMEOVER: begin
            leds_on <= 1'b0;
            busy    <= 1'b0;
          end
          default: begin
            state <= S_CLEAR;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
